// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment capture monitor: segment patterns and FSM states.
package seg7_pkg;

  localparam int unsigned SEG_W = 7;
  localparam int unsigned NIB_W = 4;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b111_1111;

  // Active-low abc_defg pattern for each hex nibble, index = nibble value.
  localparam logic [SEG_W-1:0] SEG_TABLE [16] = '{
    7'b000_0001, 7'b100_1111, 7'b001_0010, 7'b000_0110,
    7'b100_1100, 7'b010_0100, 7'b010_0000, 7'b000_1111,
    7'b000_0000, 7'b000_1100, 7'b000_1000, 7'b110_0000,
    7'b011_0001, 7'b100_0010, 7'b011_0000, 7'b011_1000
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HELD   = 2'd2
  } state_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational inverse of the hex-to-7-segment encoder.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [SEG_W-1:0] seg,
  output logic [NIB_W-1:0] nibble_c,
  output logic             blank_c,
  output logic             illegal_c
);

  always_comb begin
    nibble_c  = '0;
    blank_c   = 1'b0;
    illegal_c = 1'b1;
    if (seg == SEG_BLANK) begin
      blank_c   = 1'b1;
      illegal_c = 1'b0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (seg == SEG_TABLE[i]) begin
          nibble_c  = NIB_W'(i);
          illegal_c = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/seg7_capture.sv
// Monitors a multiplexed active-low 7-segment bus and recovers each digit's nibble.
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_DIGITS-1:0]   an_n,
  input  logic [SEG_W-1:0]        seg_n,
  output logic                    digit_stb,
  output logic [2:0]              digit_idx,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic [NUM_DIGITS-1:0]   blank,
  output logic [NUM_DIGITS-1:0]   illegal,
  output logic                    frame_stb
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned ZC_W  = 4;

  logic [NUM_DIGITS-1:0] an_q, an_prev;
  logic [SEG_W-1:0]      seg_q, seg_prev;
  logic [NUM_DIGITS-1:0] seen;
  logic [NUM_DIGITS-1:0] seen_upd;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              capture;
  logic              sel_valid;
  logic [IDX_W-1:0]  sel_idx;
  logic [ZC_W-1:0]   zeros;
  logic              pair_same;

  logic [NIB_W-1:0]  dec_nibble;
  logic              dec_blank;
  logic              dec_illegal;

  seg7_decode u_decode (
    .seg       (seg_q),
    .nibble_c  (dec_nibble),
    .blank_c   (dec_blank),
    .illegal_c (dec_illegal)
  );

  // Select is valid only with exactly one low anode bit.
  always_comb begin
    zeros   = '0;
    sel_idx = '0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (!an_q[i]) begin
        zeros   = zeros + ZC_W'(1);
        sel_idx = IDX_W'(i);
      end
    end
    sel_valid = (zeros == ZC_W'(1));
  end

  assign pair_same = (an_q == an_prev) && (seg_q == seg_prev);
  assign seen_upd  = seen | (NUM_DIGITS'(1) << sel_idx);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state, settle counter and capture decision.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    if (!sel_valid) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else if (state == HELD && pair_same) begin
      state_nxt = HELD;
    end else begin
      if (state == SETTLE && pair_same) cnt_nxt = cnt + CNT_W'(1);
      else                              cnt_nxt = CNT_W'(1);
      state_nxt = SETTLE;
      if (cnt_nxt == CNT_W'(STABLE_CYCLES)) begin
        capture   = 1'b1;
        state_nxt = HELD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      an_q     <= '1;
      an_prev  <= '1;
      seg_q    <= SEG_BLANK;
      seg_prev <= SEG_BLANK;
      cnt      <= '0;
    end else begin
      an_q     <= an_n;
      an_prev  <= an_q;
      seg_q    <= seg_n;
      seg_prev <= seg_q;
      cnt      <= cnt_nxt;
    end
  end

  // Capture registers; the completing digit's value lands with frame_stb.
  always_ff @(posedge clk) begin
    if (rst) begin
      digit_stb <= 1'b0;
      frame_stb <= 1'b0;
      digit_idx <= '0;
      value     <= '0;
      blank     <= '0;
      illegal   <= '0;
      seen      <= '0;
    end else begin
      digit_stb <= capture;
      frame_stb <= capture && (&seen_upd);
      if (capture) begin
        digit_idx <= sel_idx;
        seen      <= (&seen_upd) ? '0 : seen_upd;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
          if (sel_idx == IDX_W'(i)) begin
            value[4*i +: 4] <= dec_nibble;
            blank[i]        <= dec_blank;
            illegal[i]      <= dec_illegal;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_capture.sv
// Randomized scoreboard bench for seg7_capture against a dwell-based reference model.
module tb_seg7_capture;

  localparam int ND = 4;
  localparam int S  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [ND-1:0] an_n;
  logic [6:0]    seg_n;
  logic          digit_stb;
  logic [2:0]    digit_idx;
  logic [4*ND-1:0] value;
  logic [ND-1:0] blank;
  logic [ND-1:0] illegal;
  logic          frame_stb;

  seg7_capture #(.NUM_DIGITS(ND), .STABLE_CYCLES(S)) dut (
    .clk       (clk),
    .rst       (rst),
    .an_n      (an_n),
    .seg_n     (seg_n),
    .digit_stb (digit_stb),
    .digit_idx (digit_idx),
    .value     (value),
    .blank     (blank),
    .illegal   (illegal),
    .frame_stb (frame_stb)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    int          idx;
    logic [15:0] val;
    logic [3:0]  blk;
    logic [3:0]  ill;
    logic        frame;
  } exp_t;

  exp_t q[$];

  int  passes = 0;
  int  total  = 0;
  bit  done   = 0;

  logic [6:0] ref_tab [16];
  initial begin
    ref_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
  end

  // Reference state: current run of identical port pairs and visible outputs.
  logic [3:0]  run_an;
  logic [6:0]  run_seg;
  int          run_len = 0;
  bit          pend = 0;
  int          pend_idx;
  logic [6:0]  pend_seg;
  logic [15:0] m_val  = '0;
  logic [3:0]  m_blk  = '0;
  logic [3:0]  m_ill  = '0;
  logic [3:0]  m_seen = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passes++;
    else $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
  endtask

  function automatic bit one_low(input logic [3:0] a);
    return $countones(~a) == 1;
  endfunction

  function automatic int low_idx(input logic [3:0] a);
    for (int i = 0; i < 4; i++) if (!a[i]) return i;
    return 0;
  endfunction

  task automatic apply_capture();
    exp_t e;
    logic [3:0] nib;
    logic bl, il;
    nib = 4'h0; bl = 1'b0; il = 1'b1;
    if (pend_seg == 7'b1111111) begin bl = 1'b1; il = 1'b0; end
    else for (int i = 0; i < 16; i++) if (ref_tab[i] == pend_seg) begin nib = 4'(i); il = 1'b0; end
    m_val[4*pend_idx +: 4] = nib;
    m_blk[pend_idx] = bl;
    m_ill[pend_idx] = il;
    m_seen[pend_idx] = 1'b1;
    e.frame = (m_seen == 4'hF);
    if (e.frame) m_seen = '0;
    e.cyc = cyc; e.idx = pend_idx; e.val = m_val; e.blk = m_blk; e.ill = m_ill;
    q.push_back(e);
  endtask

  // A valid pair held for S consecutive sampled edges is captured one edge later.
  task automatic model(input logic [3:0] a, input logic [6:0] s, input logic r);
    if (r) begin
      run_len = 0; pend = 0;
      m_val = '0; m_blk = '0; m_ill = '0; m_seen = '0;
    end else begin
      if (pend) begin apply_capture(); pend = 0; end
      if (run_len > 0 && a == run_an && s == run_seg) run_len++;
      else begin run_an = a; run_seg = s; run_len = 1; end
      if (run_len == S && one_low(a)) begin
        pend = 1; pend_idx = low_idx(a); pend_seg = s;
      end
    end
  endtask

  task automatic step(input logic [3:0] a, input logic [6:0] s, input logic r);
    an_n = a; seg_n = s; rst = r;
    @(posedge clk); #1;
    model(a, s, r);
  endtask

  task automatic dwell(input logic [3:0] a, input logic [6:0] s, input int n);
    for (int i = 0; i < n; i++) step(a, s, 1'b0);
  endtask

  // Monitor: pop and compare on every digit strobe; flag missed or spurious pulses.
  always @(negedge clk) begin
    if (!done) begin
      if (digit_stb === 1'b1) begin
        if (q.size() == 0) check("unexpected_digit_stb", 32'(digit_idx), 32'hFFFF_FFFF);
        else begin
          exp_t e;
          e = q.pop_front();
          check("stb_cycle", 32'(cyc), 32'(e.cyc));
          check("digit_idx", 32'(digit_idx), 32'(e.idx));
          check("value", 32'(value), 32'(e.val));
          check("blank", 32'(blank), 32'(e.blk));
          check("illegal", 32'(illegal), 32'(e.ill));
          check("frame_stb", 32'(frame_stb), 32'(e.frame));
        end
      end else begin
        if (frame_stb !== 1'b0) check("frame_without_digit", 32'(frame_stb), 32'h0);
        if (q.size() > 0 && q[0].cyc < cyc) begin
          check("missed_digit_stb", 32'(cyc), 32'(q[0].cyc));
          void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [3:0] a;
    logic [6:0] s;
    int idx, len, sel;

    // Reset with arbitrary inputs
    step(4'($urandom), 7'($urandom), 1'b1);
    step(4'($urandom), 7'($urandom), 1'b1);
    check("reset_value", 32'(value), 32'h0);
    check("reset_blank", 32'(blank), 32'h0);
    check("reset_illegal", 32'(illegal), 32'h0);
    check("reset_digit_stb", 32'(digit_stb), 32'h0);
    check("reset_frame_stb", 32'(frame_stb), 32'h0);

    // Full frame
    dwell(4'b1110, 7'b0111000, 8);
    dwell(4'b1101, 7'b0100100, 8);
    dwell(4'b1011, 7'b0001000, 8);
    dwell(4'b0111, 7'b0000110, 8);
    dwell(4'b1111, 7'b1111111, 3);
    check("frame_value", 32'(value), 32'h3A5F);

    // Glitch rejection then exact-length dwell
    dwell(4'b1110, 7'b0000000, 3);
    dwell(4'b1111, 7'b0000000, 3);
    check("glitch_value_held", 32'(value), 32'h3A5F);
    dwell(4'b1110, 7'b0000000, 4);
    dwell(4'b1111, 7'b0000000, 3);

    // Blank and illegal
    dwell(4'b1110, 7'b0000001, 6);
    dwell(4'b1101, 7'b1111110, 6);
    dwell(4'b1011, 7'b1111111, 6);
    dwell(4'b0111, 7'b0010010, 6);
    dwell(4'b1111, 7'b1111111, 3);
    check("blank_flags", 32'(blank), 32'h4);
    check("illegal_flags", 32'(illegal), 32'h2);
    check("blank_illegal_nibbles", 32'(value[11:4]), 32'h0);

    // Invalid select
    dwell(4'b1100, 7'b1001111, 10);
    dwell(4'b1110, 7'b1001111, 6);

    // Reset mid-settle, then a fresh frame
    dwell(4'b1101, 7'b0110001, 2);
    step(4'b1101, 7'b0110001, 1'b1);
    dwell(4'b1101, 7'b0110001, 5);
    dwell(4'b1011, 7'b1000010, 5);
    dwell(4'b0111, 7'b0110000, 5);
    dwell(4'b1110, 7'b0001100, 5);

    // Randomized dwells
    for (int n = 0; n < 300; n++) begin
      idx = int'($urandom_range(0, ND - 1));
      a = ~(4'(1) << idx);
      if ($urandom_range(0, 7) == 0) a = 4'($urandom);
      sel = int'($urandom_range(0, 9));
      if (sel < 7)       s = ref_tab[$urandom_range(0, 15)];
      else if (sel == 7) s = 7'b1111111;
      else               s = 7'($urandom);
      len = int'($urandom_range(1, 8));
      if ($urandom_range(0, 39) == 0) begin
        for (int k = 0; k < int'($urandom_range(1, 2)); k++) step(a, s, 1'b1);
      end
      dwell(a, s, len);
    end

    dwell(4'b1111, 7'b1111111, 10);
    check("scoreboard_drained", 32'(q.size()), 32'h0);
    check("final_value", 32'(value), 32'(m_val));
    check("final_blank", 32'(blank), 32'(m_blk));
    check("final_illegal", 32'(illegal), 32'(m_ill));
    done = 1;
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
